// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory port of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_seg;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_e;
    logic              mem_we;
    logic              mem_seg;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_seg, d_addr, d_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_e, mem_we, mem_seg, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_seg, d_addr, d_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_e, mem_we, mem_seg, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store traffic.
// Each access runs IDLE -> ISSUE -> (WAIT x MEM_LAT for reads) -> IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst_b,
    mem_port_arbiter_if.slave      bus,
    output logic                   busy
);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e            state_q, state_d;
    logic              own_d_q, own_d_d;   // 1: data port owns the access
    logic              we_q, we_d;
    logic              seg_q, seg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              f_rvalid_q, f_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            own_d_q    <= 1'b0;
            we_q       <= 1'b0;
            seg_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            starve_q   <= '0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            own_d_q    <= own_d_d;
            we_q       <= we_d;
            seg_q      <= seg_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            f_rvalid_q <= f_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        own_d_d    = own_d_q;
        we_d       = we_q;
        seg_d      = seg_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        f_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (!bus.f_req) starve_d = '0;
                // Data wins unless fetch has been passed over STARVE_MAX times in a row.
                if (bus.d_req && !(bus.f_req && starve_q == CNT_W'(STARVE_MAX))) begin
                    state_d = ISSUE;
                    own_d_d = 1'b1;
                    we_d    = bus.d_we;
                    seg_d   = bus.d_seg;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    if (bus.f_req) starve_d = starve_q + CNT_W'(1);
                end else if (bus.f_req) begin
                    state_d  = ISSUE;
                    own_d_d  = 1'b0;
                    we_d     = 1'b0;
                    seg_d    = 1'b0;
                    addr_d   = bus.f_addr;
                    wdata_d  = '0;
                    starve_d = '0;
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : WAIT;
                lat_d   = LAT_W'(MEM_LAT - 1);
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = IDLE;
                    if (own_d_q) begin
                        d_rdata_d  = bus.mem_rdata;
                        d_rvalid_d = 1'b1;
                    end else begin
                        f_rdata_d  = bus.mem_rdata;
                        f_rvalid_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic issue;
    assign issue         = (state_q == ISSUE);
    assign busy          = (state_q != IDLE);
    assign bus.mem_e     = issue;
    assign bus.mem_we    = issue & we_q;
    assign bus.mem_seg   = issue & seg_q;
    assign bus.mem_addr  = issue ? addr_q  : '0;
    assign bus.mem_wdata = issue ? wdata_q : '0;
    assign bus.f_gnt     = issue & ~own_d_q;
    assign bus.d_gnt     = issue &  own_d_q;
    assign bus.f_rvalid  = f_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration and memory timing rules.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int STARVE = 3;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic busy1, busy3;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(STARVE)) dut1 (
        .clk(clk), .rst_b(rst_b), .bus(b1.slave), .busy(busy1));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(STARVE)) dut3 (
        .clk(clk), .rst_b(rst_b), .bus(b3.slave), .busy(busy3));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b1.f_req = 0; b1.f_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_seg = 0;
        b1.d_addr = '0; b1.d_wdata = '0; b1.mem_rdata = '0;
        b3.f_req = 0; b3.f_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_seg = 0;
        b3.d_addr = '0; b3.d_wdata = '0; b3.mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_b = 0;
        tick(); tick();
        rst_b = 1;
        tick();
        n_cmp++;
        if ({b1.f_gnt, b1.f_rvalid, b1.d_gnt, b1.d_rvalid, b1.mem_e, b1.mem_we, b1.mem_seg, busy1} !== 8'h0) begin
            n_bad++; $display("FAIL reset_ctrl1: got %b want 00000000",
                {b1.f_gnt, b1.f_rvalid, b1.d_gnt, b1.d_rvalid, b1.mem_e, b1.mem_we, b1.mem_seg, busy1});
        end
        n_cmp++;
        if ({b1.mem_addr, b1.mem_wdata, b1.f_rdata, b1.d_rdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_data1: got %h want 0", {b1.mem_addr, b1.mem_wdata, b1.f_rdata, b1.d_rdata});
        end
        n_cmp++;
        if ({b3.f_gnt, b3.d_gnt, b3.mem_e, busy3} !== 4'h0) begin
            n_bad++; $display("FAIL reset_ctrl3: got %b want 0000", {b3.f_gnt, b3.d_gnt, b3.mem_e, busy3});
        end
    endtask

    task automatic test_fetch();
        b1.f_req = 1; b1.f_addr = 16'h0004;
        tick();
        n_cmp++;
        if ({b1.f_gnt, b1.d_gnt, b1.mem_e, b1.mem_we, b1.mem_addr, busy1} !== {4'b1010, 16'h0004, 1'b1}) begin
            n_bad++; $display("FAIL fetch_issue: got gnt/dgnt/e/we %b addr %h busy %b want 1010 0004 1",
                {b1.f_gnt, b1.d_gnt, b1.mem_e, b1.mem_we}, b1.mem_addr, busy1);
        end
        b1.f_req = 0;
        tick();
        n_cmp++;
        if ({b1.f_gnt, b1.mem_e, b1.f_rvalid, busy1} !== 4'b0001) begin
            n_bad++; $display("FAIL fetch_wait: got %b want 0001", {b1.f_gnt, b1.mem_e, b1.f_rvalid, busy1});
        end
        b1.mem_rdata = 16'h1234;
        tick();
        b1.mem_rdata = 16'h0000;
        n_cmp++;
        if ({b1.f_rvalid, b1.f_rdata, busy1} !== {1'b1, 16'h1234, 1'b0}) begin
            n_bad++; $display("FAIL fetch_rvalid: got rv %b data %h busy %b want 1 1234 0", b1.f_rvalid, b1.f_rdata, busy1);
        end
        tick();
        n_cmp++;
        if ({b1.f_rvalid, b1.f_rdata} !== {1'b0, 16'h1234}) begin
            n_bad++; $display("FAIL fetch_hold: got rv %b data %h want 0 1234", b1.f_rvalid, b1.f_rdata);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic seen_rv;
        b1.f_req = 1; b1.f_addr = 16'h0010;
        tick();
        b1.f_req = 0;
        tick();
        b1.mem_rdata = 16'h7777;
        #2 rst_b = 0;
        #1;
        n_cmp++;
        if ({b1.f_gnt, b1.f_rvalid, b1.mem_e, busy1, b1.mem_addr, b1.f_rdata} !== 36'h0) begin
            n_bad++; $display("FAIL reset_mid_wait: got gnt/rv/e/busy %b addr %h rdata %h want all 0",
                {b1.f_gnt, b1.f_rvalid, b1.mem_e, busy1}, b1.mem_addr, b1.f_rdata);
        end
        tick();
        b1.mem_rdata = 16'h0000;
        rst_b = 1;
        seen_rv = 0;
        repeat (4) begin
            tick();
            seen_rv |= b1.f_rvalid;
        end
        n_cmp++;
        if (seen_rv !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_rvalid: got f_rvalid seen %b want 0", seen_rv);
        end
    endtask

    task automatic test_store();
        b1.d_req = 1; b1.d_we = 1; b1.d_seg = 1; b1.d_addr = 16'h0100; b1.d_wdata = 16'hBEEF;
        tick();
        n_cmp++;
        if ({b1.d_gnt, b1.f_gnt, b1.mem_e, b1.mem_we, b1.mem_seg, b1.mem_addr, b1.mem_wdata} !==
            {5'b10111, 16'h0100, 16'hBEEF}) begin
            n_bad++; $display("FAIL store_issue: got gnt/fgnt/e/we/seg %b addr %h wdata %h want 10111 0100 beef",
                {b1.d_gnt, b1.f_gnt, b1.mem_e, b1.mem_we, b1.mem_seg}, b1.mem_addr, b1.mem_wdata);
        end
        b1.d_req = 0; b1.d_we = 0; b1.d_seg = 0;
        tick();
        n_cmp++;
        if ({busy1, b1.d_gnt, b1.d_rvalid, b1.mem_e} !== 4'b0000) begin
            n_bad++; $display("FAIL store_done: got busy/gnt/rv/e %b want 0000", {busy1, b1.d_gnt, b1.d_rvalid, b1.mem_e});
        end
        tick();
        n_cmp++;
        if (b1.d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL store_no_rvalid: got %b want 0", b1.d_rvalid);
        end
    endtask

    task automatic test_conflict();
        b1.f_req = 1; b1.f_addr = 16'h0008;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 16'h0040;
        tick();
        n_cmp++;
        if ({b1.d_gnt, b1.f_gnt, b1.mem_addr} !== {2'b10, 16'h0040}) begin
            n_bad++; $display("FAIL conflict_data_first: got dgnt/fgnt %b addr %h want 10 0040",
                {b1.d_gnt, b1.f_gnt}, b1.mem_addr);
        end
        b1.d_req = 0;
        tick();
        b1.mem_rdata = 16'h5555;
        tick();
        b1.mem_rdata = 16'h0000;
        n_cmp++;
        if ({b1.d_rvalid, b1.d_rdata, b1.f_gnt} !== {1'b1, 16'h5555, 1'b0}) begin
            n_bad++; $display("FAIL conflict_load: got rv %b data %h fgnt %b want 1 5555 0",
                b1.d_rvalid, b1.d_rdata, b1.f_gnt);
        end
        tick();
        n_cmp++;
        if ({b1.f_gnt, b1.d_gnt, b1.mem_addr} !== {2'b10, 16'h0008}) begin
            n_bad++; $display("FAIL conflict_fetch_next: got fgnt/dgnt %b addr %h want 10 0008",
                {b1.f_gnt, b1.d_gnt}, b1.mem_addr);
        end
        b1.f_req = 0;
        tick();
        b1.mem_rdata = 16'h6666;
        tick();
        b1.mem_rdata = 16'h0000;
        n_cmp++;
        if ({b1.f_rvalid, b1.f_rdata} !== {1'b1, 16'h6666}) begin
            n_bad++; $display("FAIL conflict_fetch_data: got rv %b data %h want 1 6666", b1.f_rvalid, b1.f_rdata);
        end
    endtask

    task automatic test_starvation();
        logic [4:0] seq;
        int k;
        seq = '0; k = 0;
        b1.f_req = 1; b1.f_addr = 16'h0030;
        b1.d_req = 1; b1.d_we = 1; b1.d_addr = 16'h0200; b1.d_wdata = 16'h1111;
        for (int c = 0; c < 40 && k < 5; c++) begin
            tick();
            if (b1.d_gnt) k++;
            if (b1.f_gnt) begin
                seq[k] = 1'b1;
                k++;
                b1.f_req = 0;
            end
        end
        b1.d_req = 0; b1.d_we = 0; b1.f_req = 0;
        n_cmp++;
        if (k !== 5) begin
            n_bad++; $display("FAIL starve_timeout: got %0d grants want 5", k);
        end
        n_cmp++;
        if (seq !== 5'b01000) begin
            n_bad++; $display("FAIL starve_order: got fetch-slot mask %b want 01000 (D,D,D,F,D)", seq);
        end
        repeat (4) tick();
    endtask

    task automatic test_latency();
        int c;
        c = 0;
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 16'h0020;
        while (c < 20) begin
            tick();
            c++;
            if (b3.d_gnt) b3.d_req = 0;
            b3.mem_rdata = (c == 4) ? 16'hA5A5 : 16'h0000;
            if (b3.d_rvalid) break;
        end
        b3.d_req = 0; b3.mem_rdata = '0;
        n_cmp++;
        if (c !== 5) begin
            n_bad++; $display("FAIL latency_lat3: got d_rvalid at cycle %0d want 5", c);
        end
        n_cmp++;
        if (b3.d_rdata !== 16'hA5A5) begin
            n_bad++; $display("FAIL latency_data: got %h want a5a5", b3.d_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] memarr [16];
        logic        f_pend, d_pend, m_iss, m_own_d, m_we, m_seg, m_idle, rv_own_d;
        logic [15:0] m_addr, m_wd, rd_val, rv_data, got;
        int          cyc, rd_cyc, rv_cyc, m_wait, m_starve;
        for (int i = 0; i < 16; i++) memarr[i] = 16'($urandom);
        idle_inputs();
        rst_b = 0;
        tick();
        rst_b = 1;
        f_pend = 0; d_pend = 0; m_iss = 0; m_own_d = 0; m_we = 0; m_seg = 0; rv_own_d = 0;
        m_addr = '0; m_wd = '0; rd_val = '0; rv_data = '0;
        cyc = 0; rd_cyc = -1; rv_cyc = -1; m_wait = 0; m_starve = 0;
        repeat (1500) begin
            tick();
            cyc++;
            m_idle = !m_iss && (m_wait == 0);
            n_cmp++;
            if ({b1.f_gnt, b1.d_gnt, b1.mem_e, busy1} !== {m_iss && !m_own_d, m_iss && m_own_d, m_iss, !m_idle}) begin
                n_bad++; $display("FAIL rnd_ctrl cyc %0d: got fgnt/dgnt/e/busy %b want %b", cyc,
                    {b1.f_gnt, b1.d_gnt, b1.mem_e, busy1}, {m_iss && !m_own_d, m_iss && m_own_d, m_iss, !m_idle});
            end
            if (m_iss) begin
                n_cmp++;
                if ({b1.mem_addr, b1.mem_we, b1.mem_seg} !== {m_addr, m_we, m_seg}) begin
                    n_bad++; $display("FAIL rnd_bus cyc %0d: got addr %h we %b seg %b want %h %b %b", cyc,
                        b1.mem_addr, b1.mem_we, b1.mem_seg, m_addr, m_we, m_seg);
                end
                if (m_we) begin
                    n_cmp++;
                    if (b1.mem_wdata !== m_wd) begin
                        n_bad++; $display("FAIL rnd_wdata cyc %0d: got %h want %h", cyc, b1.mem_wdata, m_wd);
                    end
                end
            end
            n_cmp++;
            if ({b1.f_rvalid, b1.d_rvalid} !== {cyc == rv_cyc && !rv_own_d, cyc == rv_cyc && rv_own_d}) begin
                n_bad++; $display("FAIL rnd_rvalid cyc %0d: got f/d %b want %b", cyc, {b1.f_rvalid, b1.d_rvalid},
                    {cyc == rv_cyc && !rv_own_d, cyc == rv_cyc && rv_own_d});
            end
            if (cyc == rv_cyc) begin
                got = rv_own_d ? b1.d_rdata : b1.f_rdata;
                n_cmp++;
                if (got !== rv_data) begin
                    n_bad++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", cyc, got, rv_data);
                end
            end
            // Memory: stores land at issue, reads answer one cycle after issue.
            if (b1.mem_e && b1.mem_we) memarr[b1.mem_addr[3:0]] = b1.mem_wdata;
            if (b1.mem_e && !b1.mem_we) begin
                rd_cyc = cyc + 1;
                rd_val = memarr[b1.mem_addr[3:0]];
            end
            b1.mem_rdata = (cyc == rd_cyc) ? rd_val : 16'($urandom);
            if (b1.f_gnt) f_pend = 0;
            if (b1.d_gnt) d_pend = 0;
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1;
                b1.f_addr = 16'($urandom_range(0, 15));
            end
            if (!d_pend && $urandom_range(0, 9) < 7) begin
                d_pend = 1;
                b1.d_we = 1'($urandom);
                b1.d_seg = 1'($urandom);
                b1.d_addr = 16'($urandom_range(0, 15));
                b1.d_wdata = 16'($urandom);
            end
            b1.f_req = f_pend;
            b1.d_req = d_pend;
            if (m_idle) begin
                if (!f_pend) m_starve = 0;
                if (d_pend && !(f_pend && m_starve == STARVE)) begin
                    m_iss = 1; m_own_d = 1; m_addr = b1.d_addr; m_we = b1.d_we;
                    m_seg = b1.d_seg; m_wd = b1.d_wdata;
                    if (f_pend) m_starve++;
                end else if (f_pend) begin
                    m_iss = 1; m_own_d = 0; m_addr = b1.f_addr; m_we = 0; m_seg = 0;
                    m_starve = 0;
                end
            end else if (m_iss) begin
                m_iss = 0;
                if (!m_we) begin
                    m_wait = 1;
                    rv_cyc = cyc + 2;
                    rv_own_d = m_own_d;
                    rv_data = memarr[m_addr[3:0]];
                end
            end else begin
                m_wait--;
            end
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_reset_mid_wait();
        test_store();
        test_conflict();
        test_starvation();
        test_latency();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
